// File: rtl/btn_conditioner.sv
// btn_conditioner: debounced, auto-repeating push-button step requests with conflict suppression
module btn_channel #(
    parameter int unsigned DEBOUNCE_CYCLES = 512,
    parameter int unsigned REPEAT_DELAY    = 6250,
    parameter int unsigned REPEAT_PERIOD   = 625
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic ev,
    output logic held_nxt
);
    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;
    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] RD_LAST = 16'(REPEAT_DELAY - 1);
    localparam logic [15:0] RP_LAST = 16'(REPEAT_PERIOD - 1);
    state_t state, state_nxt;
    logic s1, s2;
    logic [15:0] db_cnt, db_nxt, rp_cnt, rp_nxt;
    logic first, first_nxt;
    // synchroniser, state and counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            state  <= IDLE;
            db_cnt <= '0;
            rp_cnt <= '0;
            first  <= 1'b0;
        end else begin
            s1     <= btn;
            s2     <= s1;
            state  <= state_nxt;
            db_cnt <= db_nxt;
            rp_cnt <= rp_nxt;
            first  <= first_nxt;
        end
    end
    // debounce / repeat FSM; repeat counter and first flag survive a release bounce
    always_comb begin
        state_nxt = state;
        db_nxt    = db_cnt;
        rp_nxt    = rp_cnt;
        first_nxt = first;
        ev        = 1'b0;
        case (state)
            IDLE: if (s2) begin
                state_nxt = PRESS_DB;
                db_nxt    = '0;
            end
            PRESS_DB: if (!s2) begin
                state_nxt = IDLE;
                db_nxt    = '0;
            end else if (db_cnt == DB_LAST) begin
                state_nxt = HELD;
                db_nxt    = '0;
                rp_nxt    = '0;
                first_nxt = 1'b1;
                ev        = 1'b1;
            end else begin
                db_nxt = db_cnt + 16'd1;
            end
            HELD: if (!s2) begin
                state_nxt = RELEASE_DB;
                db_nxt    = '0;
            end else if (rp_cnt == (first ? RD_LAST : RP_LAST)) begin
                rp_nxt    = '0;
                first_nxt = 1'b0;
                ev        = 1'b1;
            end else begin
                rp_nxt = rp_cnt + 16'd1;
            end
            default: if (s2) begin
                state_nxt = HELD;
                db_nxt    = '0;
            end else if (db_cnt == DB_LAST) begin
                state_nxt = IDLE;
                db_nxt    = '0;
                rp_nxt    = '0;
                first_nxt = 1'b0;
            end else begin
                db_nxt = db_cnt + 16'd1;
            end
        endcase
        held_nxt = (state_nxt == HELD) || (state_nxt == RELEASE_DB);
    end
endmodule

module btn_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 512,
    parameter int unsigned REPEAT_DELAY    = 6250,
    parameter int unsigned REPEAT_PERIOD   = 625
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_incr,
    input  logic btn_decr,
    output logic incr_pulse,
    output logic decr_pulse,
    output logic incr_held,
    output logic decr_held,
    output logic conflict
);
    logic incr_ev, decr_ev, incr_held_nxt, decr_held_nxt;
    btn_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_incr (
        .clk(clk),
        .rst_n(rst_n),
        .btn(btn_incr),
        .ev(incr_ev),
        .held_nxt(incr_held_nxt)
    );
    btn_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_decr (
        .clk(clk),
        .rst_n(rst_n),
        .btn(btn_decr),
        .ev(decr_ev),
        .held_nxt(decr_held_nxt)
    );
    // arbitrate against the opposite button's held state as it will read after this edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            incr_pulse <= 1'b0;
            decr_pulse <= 1'b0;
            incr_held  <= 1'b0;
            decr_held  <= 1'b0;
            conflict   <= 1'b0;
        end else begin
            incr_pulse <= incr_ev & ~decr_held_nxt;
            decr_pulse <= decr_ev & ~incr_held_nxt;
            incr_held  <= incr_held_nxt;
            decr_held  <= decr_held_nxt;
            conflict   <= incr_held_nxt & decr_held_nxt;
        end
    end
endmodule
